// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped I/O block for the three-stage RV32 core.
// Decodes loads/stores whose addr[31:28] matches IO_BASE, buffers UART
// traffic in RX/TX FIFOs and keeps free-running cycle and retired-instruction
// counters. Load data is registered (one-cycle latency, like the synchronous
// memories).
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   addr/wdata/we/re  CPU load/store interface (EX-stage address)
//   rdata             registered load data, valid the cycle after re
//   inst_retire       one pulse per retired instruction
//   tx_data/tx_valid/tx_ready  TX FIFO head towards the UART transmitter
//   rx_data/rx_valid/rx_ready  RX FIFO tail from the UART receiver
//   irq               RX level interrupt
//
// Optional feature macro: IO_IRQ_EN adds the RX threshold register at 0x1C and
// the registered irq output; without it irq is tied low.
module mmio_io_ctrl #(
  parameter logic [3:0]  IO_BASE  = 4'h8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_LEVELS = 8'h0C;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;
  localparam logic [7:0] OFF_IRQTH  = 8'h1C;

  // Address decode
  logic       hit;
  logic [7:0] off;
  logic       store;
  logic       load;

  assign hit   = (addr[31:28] == IO_BASE);
  assign off   = addr[7:0];
  assign store = hit && (we != 4'b0);
  assign load  = hit && re;

  // FIFO state
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_wr_sel, rx_push, rx_pop;
  logic ovf, ovf_set, ovf_clr, ctr_clr;
  logic [31:0] cyc_cnt, inst_cnt;
  logic [31:0] rd_c;
  logic [7:0]  irq_thr_c;

  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd_ptr];
  assign tx_pop   = tx_valid && tx_ready;

  // A full TX FIFO still takes a CPU byte when the transmitter drains one on
  // the same edge; only a truly blocked write is dropped and flagged.
  assign tx_wr_sel = store && (off == OFF_TXDATA);
  assign tx_push   = tx_wr_sel && (!tx_full || tx_pop);
  assign ovf_set   = tx_wr_sel && tx_full && !tx_pop;
  assign ovf_clr   = load && (off == OFF_STATUS);

  // A CPU pop frees a slot on the same edge, so a full RX FIFO can still
  // accept a byte while being read.
  assign rx_pop   = load && (off == OFF_RXDATA) && !rx_empty;
  assign rx_ready = !rx_full || rx_pop;
  assign rx_push  = rx_valid && rx_ready;

  assign ctr_clr = store && (off == OFF_CLR);

  // TX FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // FIFO storage (no reset; emptiness is tracked by the pointers)
  always_ff @(posedge clk) begin
    if (!rst && tx_push) tx_mem[tx_wr_ptr] <= wdata[7:0];
    if (!rst && rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Free-running counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || ctr_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

`ifdef IO_IRQ_EN
  logic [7:0] irq_thr;

  // RX level interrupt with programmable threshold (0 disables)
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_thr <= 8'd1;
      irq     <= 1'b0;
    end else begin
      if (store && (off == OFF_IRQTH)) irq_thr <= wdata[7:0];
      irq <= (9'(rx_count) >= 9'(irq_thr)) && (irq_thr != 8'd0);
    end
  end

  assign irq_thr_c = irq_thr;
`else
  assign irq       = 1'b0;
  assign irq_thr_c = 8'd0;
`endif

  // Read decode; sampled from pre-edge state, so a same-edge pop is invisible
  always_comb begin
    rd_c = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: rd_c = {27'b0, ovf, rx_full, tx_empty, !rx_empty, !tx_full};
        OFF_RXDATA: rd_c = rx_empty ? 32'd0 : {24'b0, rx_mem[rx_rd_ptr]};
        OFF_LEVELS: rd_c = {8'b0, 8'(tx_count), 8'b0, 8'(rx_count)};
        OFF_CYC:    rd_c = cyc_cnt;
        OFF_INST:   rd_c = inst_cnt;
        OFF_IRQTH:  rd_c = {24'b0, irq_thr_c};
        default:    rd_c = '0;
      endcase
    end
  end

  // Registered load data
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rd_c;
  end

  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl (default parameters).
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  we;
  logic        re, inst_retire;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  mmio_io_ctrl #(.IO_BASE(4'h8), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .inst_retire(inst_retire), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        check;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 4'hF;
    step();
    we = 4'h0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] e);
    vecs.push_back('{is_wr: w, a: a, d: d, check: c, exp: e});
  endtask

  initial begin
    logic [31:0] d;

    // Table: decode, unmapped offsets, TX overflow and sticky ovf
    add(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0005);
    add(1'b0, 32'h8000_000C, 32'h0, 1'b1, 32'h0000_0000);
    add(1'b0, 32'h9000_0000, 32'h0, 1'b1, 32'h0000_0000);
    add(1'b0, 32'h8000_0040, 32'h0, 1'b1, 32'h0000_0000);
    add(1'b0, 32'h8000_0004, 32'h0, 1'b1, 32'h0000_0000);
    for (int i = 0; i < 9; i++) add(1'b1, 32'h8000_0008, 32'(8'h41 + i), 1'b0, 32'h0);
    add(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0010);
    add(1'b0, 32'h8000_000C, 32'h0, 1'b1, 32'h0008_0000);
    add(1'b1, 32'h8000_0040, 32'h5A, 1'b0, 32'h0);
    add(1'b0, 32'h8000_000C, 32'h0, 1'b1, 32'h0008_0000);
    add(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0000);

    addr = '0; wdata = '0; we = '0; re = 1'b0; inst_retire = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;

    rd(32'h8000_0000, d); chk("first_status", d, 32'h5);
    rd(32'h8000_0010, d); chk("cyc_small_nonzero", 32'(d != 0 && d < 32), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
      else begin
        rd(vecs[i].a, d);
        if (vecs[i].check) chk($sformatf("vec[%0d]", i), d, vecs[i].exp);
      end
    end

    // TX drain order 0x41..0x48
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_drain[%0d]", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(8'h41 + i)});
      step();
    end
    chk("tx_empty_after_drain", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // TX full with simultaneous pop: push accepted, no overflow
    for (int i = 0; i < 8; i++) wr(32'h8000_0008, 32'(i));
    addr = 32'h8000_0008; wdata = 32'h99; we = 4'hF; tx_ready = 1'b1;
    step();
    we = 4'h0; tx_ready = 1'b0;
    rd(32'h8000_0000, d); chk("tx_full_pushpop_status", d, 32'h0);
    rd(32'h8000_000C, d); chk("tx_full_pushpop_level", d, 32'h0008_0000);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_full_order[%0d]", i), 32'(tx_data), (i == 7) ? 32'h99 : 32'(i + 1));
      step();
    end
    tx_ready = 1'b0;

    // RX basic
    rx_push(8'h55); rx_push(8'hAA);
    rd(32'h8000_000C, d); chk("rx_level2", d, 32'h2);
    rd(32'h8000_0004, d); chk("rx_pop0", d, 32'h55);
    rd(32'h8000_0004, d); chk("rx_pop1", d, 32'hAA);
    rd(32'h8000_0004, d); chk("rx_pop_empty", d, 32'h0);
    rd(32'h8000_000C, d); chk("rx_level0", d, 32'h0);

    // RX full, then pop and push together
    for (int i = 0; i < 8; i++) rx_push(8'(8'h10 + i));
    chk("rx_full_ready", 32'(rx_ready), 32'h0);
    rd(32'h8000_0000, d); chk("rx_full_status", d, 32'h0000_000F);
    addr = 32'h8000_0004; re = 1'b1; rx_data = 8'h18; rx_valid = 1'b1;
    step();
    re = 1'b0; rx_valid = 1'b0;
    chk("rx_full_pushpop_data", rdata, 32'h10);
    rd(32'h8000_000C, d); chk("rx_full_pushpop_level", d, 32'h8);
    for (int i = 1; i <= 8; i++) begin
      rd(32'h8000_0004, d);
      chk($sformatf("rx_order[%0d]", i), d, 32'(8'h10 + i));
    end

    // RX empty with pop and push together: no bypass
    addr = 32'h8000_0004; re = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    step();
    re = 1'b0; rx_valid = 1'b0;
    chk("rx_empty_pushpop_data", rdata, 32'h0);
    rd(32'h8000_000C, d); chk("rx_empty_pushpop_level", d, 32'h1);
    rd(32'h8000_0004, d); chk("rx_empty_pushpop_pop", d, 32'h77);

    // Counters: retire count, clear wins over increment
    inst_retire = 1'b1;
    repeat (5) step();
    inst_retire = 1'b0;
    rd(32'h8000_0014, d); chk("inst_cnt5", d, 32'h5);
    inst_retire = 1'b1;
    wr(32'h8000_0018, 32'h0);
    inst_retire = 1'b0;
    rd(32'h8000_0014, d); chk("inst_clr", d, 32'h0);
    rd(32'h8000_0010, d); chk("cyc_after_clr1", d, 32'h1);
    rd(32'h8000_0010, d); chk("cyc_after_clr2", d, 32'h2);

`ifdef IO_IRQ_EN
    wr(32'h8000_001C, 32'h3);
    rd(32'h8000_001C, d); chk("irq_thr", d, 32'h3);
    rx_push(8'hA1); rx_push(8'hA2);
    step(); chk("irq_at2", 32'(irq), 32'h0);
    rx_push(8'hA3); chk("irq_same_cycle", 32'(irq), 32'h0);
    step(); chk("irq_at3", 32'(irq), 32'h1);
    rd(32'h8000_0004, d);
    step(); chk("irq_after_pop", 32'(irq), 32'h0);
    rx_push(8'hA4);
    step(); chk("irq_again", 32'(irq), 32'h1);
`else
    wr(32'h8000_001C, 32'h3);
    rd(32'h8000_001C, d); chk("irq_thr_absent", d, 32'h0);
    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3);
    step(); chk("irq_tied", 32'(irq), 32'h0);
`endif

    // Reset mid-stream discards FIFO contents
    wr(32'h8000_0008, 32'h33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
    chk("midrst_rx_ready", 32'(rx_ready), 32'h1);
    rd(32'h8000_000C, d); chk("midrst_levels", d, 32'h0);
    rd(32'h8000_0004, d); chk("midrst_rx_empty", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
